// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// The optional duty-cycle counter is enabled by CLK_PERIOD_METER_DUTY_EN (see clk_period_meter.sv).
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        HOLD = 2'd3
    } meter_state_t;

    localparam int CNT_W_DEF       = 32;
    localparam int TIMEOUT_DEF     = 100000000;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level plus a one-cycle rising-edge pulse.
// SYNC_STAGES must be at least 2.
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic I_CLK,
    input  logic Rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge I_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period (and optionally high time) of a slow asynchronous signal in I_CLK cycles.
// Define CLK_PERIOD_METER_DUTY_EN to build the high-time counter; otherwise High_time is tied to 0.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             I_CLK,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Sig_in,
    output logic             Busy,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] High_time,
    output logic             Timeout,
    output logic             Valid,
    input  logic             Ready
);

    localparam logic [CNT_W-1:0] TO_MEAS = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_ARM  = CNT_W'(TIMEOUT - 1);

    meter_state_t     r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_timeout;
    logic             w_sync, w_rise;
    logic             w_arm_clr, w_meas_start, w_cnt_inc, w_capture, w_abort;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .I_CLK   (I_CLK),
        .Rst_n   (Rst_n),
        .i_async (Sig_in),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

    always_ff @(posedge I_CLK or negedge Rst_n) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A rise always wins over the timeout check so a period of exactly TIMEOUT still reports.
    always_comb begin
        w_next       = r_state;
        w_arm_clr    = 1'b0;
        w_meas_start = 1'b0;
        w_cnt_inc    = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next    = ARM;
                    w_arm_clr = 1'b1;
                end
            end
            ARM: begin
                if (w_rise) begin
                    w_next       = MEAS;
                    w_meas_start = 1'b1;
                end else if (r_cnt == TO_ARM) begin
                    w_next  = HOLD;
                    w_abort = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            MEAS: begin
                if (w_rise) begin
                    w_next    = HOLD;
                    w_capture = 1'b1;
                end else if (r_cnt == TO_MEAS) begin
                    w_next  = HOLD;
                    w_abort = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (Ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt     <= '0;
            r_period  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_arm_clr)         r_cnt <= '0;
            else if (w_meas_start) r_cnt <= CNT_W'(1);
            else if (w_cnt_inc)    r_cnt <= r_cnt + CNT_W'(1);

            if (w_capture) begin
                r_period  <= r_cnt;
                r_timeout <= 1'b0;
            end else if (w_abort) begin
                r_period  <= '0;
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_high;

    // The rise cycle itself is high, hence the preload of 1 on entry to MEAS.
    always_ff @(posedge I_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hcnt <= '0;
            r_high <= '0;
        end else begin
            if (w_meas_start)
                r_hcnt <= CNT_W'(1);
            else if (w_cnt_inc && (r_state == MEAS) && w_sync)
                r_hcnt <= r_hcnt + CNT_W'(1);

            if (w_capture)    r_high <= r_hcnt;
            else if (w_abort) r_high <= '0;
        end
    end

    assign High_time = r_high;
`else
    logic w_unused_sync;
    assign w_unused_sync = w_sync;
    assign High_time     = '0;
`endif

    assign Period  = r_period;
    assign Timeout = r_timeout;
    assign Valid   = (r_state == HOLD);
    assign Busy    = (r_state != IDLE);

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: period/high-time, timeouts, hold, ignored Start, async reset.
module tb_clk_period_meter;

    localparam int CNT_W = 32;
    localparam int TO    = 1000;
`ifdef CLK_PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             I_CLK = 1'b0;
    logic             Rst_n = 1'b0;
    logic             Start = 1'b0;
    logic             Sig_in;
    logic             Ready = 1'b0;
    logic             Busy, Valid, Timeout;
    logic [CNT_W-1:0] Period, High_time;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   gen_mode = 0;
    logic man_lvl  = 1'b0;
    int   gen_hi   = 10;
    int   gen_lo   = 10;
    int   cyc;

    always #5 I_CLK = ~I_CLK;

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TO),
        .SYNC_STAGES (2)
    ) dut (
        .I_CLK     (I_CLK),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Sig_in    (Sig_in),
        .Busy      (Busy),
        .Period    (Period),
        .High_time (High_time),
        .Timeout   (Timeout),
        .Valid     (Valid),
        .Ready     (Ready)
    );

    // Stimulus source: mode 1 = free-running gen_hi/gen_lo pattern, else constant man_lvl.
    initial begin : gen
        int pc;
        pc     = 0;
        Sig_in = 1'b0;
        forever begin
            @(negedge I_CLK);
            #2;
            if (gen_mode == 1) begin
                Sig_in = (pc < gen_hi);
                pc     = (pc + 1 >= gen_hi + gen_lo) ? 0 : pc + 1;
            end else begin
                Sig_in = man_lvl;
                pc     = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start;
        @(negedge I_CLK);
        Start = 1'b1;
        @(negedge I_CLK);
        Start = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        do begin
            @(posedge I_CLK);
            #1;
            n++;
        end while (!Valid && n < maxc);
        chk("valid_seen", Valid, 1'b1);
    endtask

    initial begin
        // Reset state
        #23;
        chk("rst_busy", Busy, 1'b0);
        chk("rst_valid", Valid, 1'b0);
        chk("rst_timeout", Timeout, 1'b0);
        chk("rst_period", Period, 0);
        chk("rst_high", High_time, 0);
        @(negedge I_CLK);
        Rst_n = 1'b1;

        // 10 high / 10 low, Ready held high
        Ready    = 1'b1;
        gen_hi   = 10;
        gen_lo   = 10;
        gen_mode = 1;
        repeat (30) @(negedge I_CLK);
        pulse_start();
        chk("t1_busy", Busy, 1'b1);
        wait_valid(100, cyc);
        chk("t1_period", Period, 20);
        chk("t1_high", High_time, DUTY ? 10 : 0);
        chk("t1_timeout", Timeout, 1'b0);
        @(posedge I_CLK); #1;
        chk("t1_valid_drop", Valid, 1'b0);
        chk("t1_idle", Busy, 1'b0);

        // 3 high / 5 low, measured twice
        gen_hi = 3;
        gen_lo = 5;
        repeat (20) @(negedge I_CLK);
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            wait_valid(60, cyc);
            chk("t2_period", Period, 8);
            chk("t2_high", High_time, DUTY ? 3 : 0);
            chk("t2_timeout", Timeout, 1'b0);
            @(posedge I_CLK); #1;
            chk("t2_valid_drop", Valid, 1'b0);
        end

        // Timeout from ARM: no edge at all
        gen_mode = 0;
        man_lvl  = 1'b0;
        repeat (10) @(negedge I_CLK);
        pulse_start();
        wait_valid(1100, cyc);
        chk("t3_arm_cycles", cyc, TO);
        chk("t3_timeout", Timeout, 1'b1);
        chk("t3_period", Period, 0);
        @(posedge I_CLK); #1;
        chk("t3_valid_drop", Valid, 1'b0);

        // Timeout from MEAS: a single rising edge
        pulse_start();
        repeat (5) @(negedge I_CLK);
        man_lvl = 1'b1;
        wait_valid(1100, cyc);
        chk("t3b_from_meas", cyc > TO, 1'b1);
        chk("t3b_timeout", Timeout, 1'b1);
        chk("t3b_period", Period, 0);
        @(posedge I_CLK); #1;
        chk("t3b_valid_drop", Valid, 1'b0);
        man_lvl = 1'b0;

        // Hold with Ready low; Start pulses in ARM, MEAS and HOLD are ignored
        Ready    = 1'b0;
        gen_hi   = 10;
        gen_lo   = 10;
        gen_mode = 1;
        repeat (10) @(negedge I_CLK);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            repeat (5) @(negedge I_CLK);
            Start = 1'b1;
            @(negedge I_CLK);
            Start = 1'b0;
        end
        chk("t4_still_busy", Busy, 1'b1);
        wait_valid(100, cyc);
        chk("t4_period", Period, 20);
        chk("t4_high", High_time, DUTY ? 10 : 0);
        for (int k = 0; k < 50; k++) begin
            @(negedge I_CLK);
            Start = (k == 10);
            @(posedge I_CLK); #1;
            chk("t4_hold_valid", Valid, 1'b1);
            chk("t4_hold_period", Period, 20);
            chk("t4_hold_high", High_time, DUTY ? 10 : 0);
        end
        // Accept while Start is high: must return to IDLE, not re-arm
        @(negedge I_CLK);
        Ready = 1'b1;
        Start = 1'b1;
        @(posedge I_CLK); #1;
        chk("t4_accept_valid", Valid, 1'b0);
        chk("t4_accept_busy", Busy, 1'b0);
        @(negedge I_CLK);
        Ready = 1'b0;
        Start = 1'b0;
        @(posedge I_CLK); #1;
        chk("t4_no_restart", Busy, 1'b0);
        chk("t4_result_kept", Period, 20);

        // Asynchronous reset in the middle of MEAS
        Ready    = 1'b1;
        gen_mode = 0;
        man_lvl  = 1'b0;
        repeat (5) @(negedge I_CLK);
        pulse_start();
        repeat (5) @(negedge I_CLK);
        man_lvl = 1'b1;
        repeat (10) @(posedge I_CLK);
        #1;
        chk("t5_pre_busy", Busy, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("t5_busy", Busy, 1'b0);
        chk("t5_valid", Valid, 1'b0);
        chk("t5_period", Period, 0);
        chk("t5_high", High_time, 0);
        chk("t5_timeout", Timeout, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge I_CLK); #1;
            chk("t5_rst_valid", Valid, 1'b0);
        end
        @(negedge I_CLK);
        #2;
        Rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge I_CLK); #1;
            chk("t5_no_valid", Valid, 1'b0);
        end
        man_lvl  = 1'b0;
        gen_hi   = 10;
        gen_lo   = 10;
        gen_mode = 1;
        repeat (30) @(negedge I_CLK);
        pulse_start();
        wait_valid(100, cyc);
        chk("t5_after_period", Period, 20);
        chk("t5_after_timeout", Timeout, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receiving-end counterpart of the team's clock dividers: measures a slow, divided or external periodic signal in units of I_CLK cycles.
- Reports the period and, optionally, the high time through a valid/ready result handshake.
- Sits beside divider outputs for self-check and frequency display.
- Input is asynchronous to I_CLK and is synchronised internally.

Parameters:
- CNT_W, 32, width of the cycle counter and of the result outputs.
- TIMEOUT, 100000000, maximum I_CLK cycles allowed in ARM or MEAS before the measurement aborts; must be < 2**CNT_W.
- SYNC_STAGES, 2, number of synchroniser flops on Sig_in; minimum 2.

Ports:
- I_CLK  input  1  system clock; all logic on its rising edge.
- Rst_n  input  1  reset; asynchronous, active-low.
- Start  input  1  single-cycle request to begin one measurement; honoured only in IDLE.
- Sig_in  input  1  signal under measurement; asynchronous to I_CLK.
- Busy  output  1  high in ARM, MEAS and HOLD.
- Period  output  CNT_W  measured period in I_CLK cycles; 0 on timeout.
- High_time  output  CNT_W  I_CLK cycles with synchronised Sig_in high within the measured period; see Optional Feature.
- Timeout  output  1  high with Valid when the measurement aborted.
- Valid  output  1  result available; held until accepted.
- Ready  input  1  consumer accepts the result when Valid&&Ready.

Behaviour:
- Reset (Rst_n=0, asynchronous): state IDLE; Busy, Valid and Timeout = 0; Period and High_time = 0; counters and synchroniser = 0.
- Sync: Sig_in passes through SYNC_STAGES flops to give s_sync. s_prev is s_sync delayed by 1. rise = s_sync & ~s_prev.
- IDLE:
  - Start=1 -> ARM; cnt <= 0.
  - Otherwise stay. Outputs Period, High_time and Timeout hold their last values; Valid=0.
- ARM (waiting for first rising edge):
  - rise -> MEAS; cnt <= 1; hcnt <= 1.
  - Otherwise cnt++. If cnt == TIMEOUT-1 -> HOLD with Timeout<=1 and Period<=0.
- MEAS:
  - Each cycle without rise: cnt++; hcnt++ when s_sync=1.
  - On rise: Period <= cnt; High_time <= hcnt; Timeout <= 0 -> HOLD.
  - If cnt reaches TIMEOUT before rise -> HOLD with Timeout<=1 and Period<=0.
  - Result: Period equals the cycle distance between consecutive rise pulses. For a 10-high/10-low signal, Period = 20.
- HOLD:
  - Valid=1; Period, High_time and Timeout stable.
  - Valid&&Ready -> IDLE; Valid drops the next cycle.
  - Ready while Valid=0 is ignored.
- Start outside IDLE is ignored, including in the acceptance cycle.
- Latency: Valid rises 1 cycle after the second rise pulse. Pin-to-rise delay is SYNC_STAGES+1 cycles.
- Counters never wrap; TIMEOUT bounds them.
- Rst_n low mid-measurement aborts immediately to reset values; no result is produced.

Optional Feature:
- Macro: CLK_PERIOD_METER_DUTY_EN.
- Defined: hcnt is implemented and High_time reports high cycles as above.
- Undefined: hcnt is removed; High_time is a constant 0. The port remains so the interface is identical in both builds.

Decomposition:
- Shared package clk_meter_pkg:
  - state enum {IDLE, ARM, MEAS, HOLD};
  - localparam default CNT_W;
  - timeout default.
- One natural sub-module: sig_sync_edge (parameter SYNC_STAGES). Inputs I_CLK, Rst_n, async in. Outputs s_sync and rise. Reusable by other blocks in the design.

Test Plan:
- Sig_in toggles every 10 I_CLK cycles (divide-by-20 pattern), Start pulse, Ready=1 -> Valid once; Period=20; High_time=10 with macro, 0 without; Timeout=0.
- Sig_in 3 high / 5 low, Start -> Period=8, High_time=3; a second Start after acceptance gives an identical result.
- TIMEOUT=1000, Sig_in held 0, Start -> Valid after 1000 cycles in ARM; Timeout=1; Period=0. Repeat with one rising edge only -> timeout from MEAS.
- Result ready with Ready=0 for 50 cycles -> Valid, Period and High_time held constant; Ready=1 for one cycle -> Valid low next cycle, state IDLE, Busy=0.
- Start pulses in ARM, MEAS and HOLD -> no restart, no change to the result.
- Rst_n pulsed low for 3 cycles mid-MEAS, asynchronous to the clock edge -> all outputs 0 immediately; Valid never asserts; after release, Start gives a correct Period.
